// File: rtl/ui5640cfg_seq.sv
// OV5640 register-table sequencer.
// Walks the table from index 0 to reg_size_i-1 and issues one SCCB write per
// entry through the shared I2C master. Waits for power-up before the first
// write and for the sensor reset after the software-reset entry. Retries
// NACKed writes a bounded number of times.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for cfg_start_i after reset
// PWRUP | power-up wait before the first write
// FETCH | compare index to size, latch addr/data from the table
// REQ   | wait for the I2C master to go idle, then pulse iic_req_o
// WAIT  | wait for iic_done_i; ack, retry or give up
// DLY   | post software-reset wait
// NEXT  | advance the table index
// DONE  | all entries written, sticky cfg_done_o
// ERR   | retry limit hit, sticky cfg_err_o
module ui5640cfg_seq #(
  parameter int unsigned CLK_FREQ      = 50000000,
  parameter int unsigned PWRUP_WAIT_US = 20000,
  parameter int unsigned RST_WAIT_US   = 5000,
  parameter int unsigned DELAY_INDEX   = 1,
  parameter int unsigned RETRY_MAX     = 3,
  parameter logic [6:0]  DEV_ADDR      = 7'h3c
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cfg_start_i,
  output logic [8:0]  reg_index_o,
  input  logic [31:0] reg_data_i,
  input  logic [8:0]  reg_size_i,
  output logic        iic_req_o,
  output logic [6:0]  iic_dev_o,
  output logic [15:0] iic_addr_o,
  output logic [7:0]  iic_wdata_o,
  input  logic        iic_busy_i,
  input  logic        iic_done_i,
  input  logic        iic_nack_i,
  output logic        cfg_busy_o,
  output logic        cfg_done_o,
  output logic        cfg_err_o,
  output logic [8:0]  cfg_err_idx_o
);

  // Cycles per microsecond tick; clocks below 1 MHz tick every cycle.
  localparam int unsigned PRESC    = (CLK_FREQ / 1000000 > 0) ? CLK_FREQ / 1000000 : 1;
  localparam logic [31:0] PRESC_TC = 32'(PRESC - 1);

  typedef enum logic [3:0] {
    IDLE, PWRUP, FETCH, REQ, WAIT, DLY, NEXT, DONE, ERR
  } state_t;

  state_t      state;
  logic [31:0] presc_cnt;
  logic [31:0] wait_cnt;
  logic [7:0]  retry;

  // Upper table byte carries no information for a write.
  logic unused_data_hi;
  assign unused_data_hi = ^reg_data_i[31:24];

  assign iic_dev_o = DEV_ADDR;

  // Sequencer FSM; all outputs registered, iic_req_o defaults low each cycle.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state         <= IDLE;
      presc_cnt     <= '0;
      wait_cnt      <= '0;
      retry         <= '0;
      reg_index_o   <= '0;
      iic_req_o     <= 1'b0;
      iic_addr_o    <= '0;
      iic_wdata_o   <= '0;
      cfg_busy_o    <= 1'b0;
      cfg_done_o    <= 1'b0;
      cfg_err_o     <= 1'b0;
      cfg_err_idx_o <= '0;
    end else begin
      iic_req_o <= 1'b0;
      case (state)
        IDLE, DONE, ERR: begin
          if (cfg_start_i) begin
            cfg_done_o    <= 1'b0;
            cfg_err_o     <= 1'b0;
            cfg_err_idx_o <= '0;
            reg_index_o   <= '0;
            cfg_busy_o    <= 1'b1;
            presc_cnt     <= PRESC_TC;
            wait_cnt      <= 32'(PWRUP_WAIT_US);
            state         <= PWRUP;
          end
        end
        PWRUP, DLY: begin
          // Tick down-counter: leave once the tick count reaches zero.
          if (wait_cnt == '0) begin
            state <= (state == PWRUP) ? FETCH : NEXT;
          end else if (presc_cnt == '0) begin
            presc_cnt <= PRESC_TC;
            wait_cnt  <= wait_cnt - 32'd1;
          end else begin
            presc_cnt <= presc_cnt - 32'd1;
          end
        end
        FETCH: begin
          if (reg_index_o >= reg_size_i) begin
            cfg_done_o <= 1'b1;
            cfg_busy_o <= 1'b0;
            state      <= DONE;
          end else begin
            iic_addr_o  <= reg_data_i[23:8];
            iic_wdata_o <= reg_data_i[7:0];
            retry       <= '0;
            state       <= REQ;
          end
        end
        REQ: begin
          if (!iic_busy_i) begin
            iic_req_o <= 1'b1;
            state     <= WAIT;
          end
        end
        WAIT: begin
          if (iic_done_i) begin
            if (!iic_nack_i) begin
              if (reg_index_o == 9'(DELAY_INDEX)) begin
                presc_cnt <= PRESC_TC;
                wait_cnt  <= 32'(RST_WAIT_US);
                state     <= DLY;
              end else begin
                state <= NEXT;
              end
            end else if (retry < 8'(RETRY_MAX)) begin
              retry <= retry + 8'd1;
              state <= REQ;
            end else begin
              cfg_err_o     <= 1'b1;
              cfg_err_idx_o <= reg_index_o;
              cfg_busy_o    <= 1'b0;
              state         <= ERR;
            end
          end
        end
        NEXT: begin
          reg_index_o <= reg_index_o + 9'd1;
          state       <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
